seg7_scan_mux: RTL
==================

// Module: seg7_scan_mux
// PURPOSE
//  Time-multiplexed 4-digit scanner that sits directly upstream of the BCD->7-segment decoder.
//  - Holds a 4-digit packed BCD value.
//  - Steps through the digits at a fixed refresh rate.
//  - Drives the decoder's 4-bit BCD input (q_out) and the active-low common-anode enables of
//    the display, so one decoder instance serves all four digits.
//  - Double-buffers the input so a new value never tears mid-frame.
// PARAMETERS
//  REFRESH_DIV   100000  clk cycles per digit slot (100 MHz -> 1 kHz/digit); legal range >= 2
//  BLANK_CYCLES  1000    ghosting guard: cycles at slot start with all anodes off; < REFRESH_DIV
// PORTS
//  clk        in   1   system clock; all logic on rising edge
//  rst_n      in   1   synchronous reset, active-low
//  bcd_in     in   16  packed BCD: [15:12]=digit3 (MSD) .. [3:0]=digit0 (LSD)
//  bcd_valid  in   1   1-cycle strobe; capture bcd_in into shadow register
//  q_out      out  4   BCD nibble of current digit; feeds decoder Q
//  anode      out  4   active-low digit enables; anode[i]=0 lights digit i
//  digit_sel  out  2   index of the digit currently in its slot
//  frame_tick out  1   1-cycle pulse in the first cycle of each digit-0 slot
// BEHAVIOUR
//  Registers and outputs
//  - All outputs are registered and computed from next-state values, so q_out, digit_sel and
//    anode always describe the same digit in the same cycle.
//  - Reset (rst_n=0 at an edge): cnt=0, digit_sel=0, disp=0, shadow=0, pending=0, q_out=0,
//    anode=4'b1111, frame_tick=0.
//  - Reset asserted mid-frame: same values at the next edge; the latched value is discarded.
//  Prescaler
//  - cnt counts 0..REFRESH_DIV-1 and wraps to 0.
//  - On wrap, digit_sel increments mod 4: 3 -> 0 is the frame boundary.
//  Anode
//  - anode[i] = 0 iff digit_sel==i AND cnt>=BLANK_CYCLES AND digit i not blanked.
//  - Otherwise 1. At most one anode bit is low at any time.
//  q_out
//  - q_out = disp[4*digit_sel +: 4], valid for the whole slot including the guard cycles.
//  - Nibbles > 9 pass through unchanged; the decoder owns their glyphs.
//  Input buffering
//  - bcd_valid: shadow <= bcd_in, pending <= 1. The last strobe before a boundary wins.
//  - Frame boundary with pending=1: disp <= shadow, pending <= 0.
//  - Frame boundary with pending=0: disp is unchanged.
//  - bcd_valid in the same cycle as the boundary: disp <= bcd_in directly, pending <= 0.
//    The new value is shown from the very first digit-0 slot.
//  frame_tick
//  - High exactly during cycle cnt==0 of each digit_sel==0 slot.
//  - First assertion is REFRESH_DIV*4 cycles after reset release, not during reset.
//  Width rules
//  - cnt width = $clog2(REFRESH_DIV).
//  - The comparison with BLANK_CYCLES is unsigned.
// CONFIGURATION
//  Macro SEG7_LZ_BLANK_EN
//  - Defined: leading-zero suppression on disp.
//    - digit3 blanked if disp[15:12]==0.
//    - digit2 blanked if disp[15:8]==0.
//    - digit1 blanked if disp[15:4]==0.
//    - digit0 never blanked.
//    - A blanked digit keeps anode high for its whole slot; scan timing, q_out and frame_tick
//      are unchanged.
//  - Undefined: no digit is ever blanked; zeros display normally.
// TESTING  (bench uses REFRESH_DIV=4, BLANK_CYCLES=1)
//  1. rst_n=0 for 2 cycles -> anode=1111, q_out=0, digit_sel=0, frame_tick=0; after release
//     all four digits show 0 (no macro).
//  2. valid 0x1234, run one frame past the boundary -> digit0 slot: q_out=4, anode 1111 for 1
//     cycle then 1110 for 3. Then q_out=3/1101, 2/1011, 1/0111. frame_tick pulses once per 16 cycles.
//  3. Showing 0x1234, valid 0x5678 during digit1 slot -> digits 2,3 still show 2,1; next
//     frame shows 8,7,6,5.
//  4. valid 0x9999 on the boundary cycle (digit_sel=3, cnt=3) -> next cycle digit_sel=0,
//     q_out=9, frame_tick=1.
//  5. SEG7_LZ_BLANK_EN defined, 0x0042 -> anode[3], anode[2] never low; digits 1,0 light with
//     4,2. 0x0000 -> only anode[0] low, q_out=0. Macro undefined, 0x0042 -> all four light.
//  6. Display 0xABCD, rst_n=0 during digit2 slot -> next edge all reset values; after release
//     disp=0 and no stale nibble appears.

Source files
------------

// File: rtl/seg7_scan_mux_if.sv
// Bus between the BCD producer and the 4-digit scanner.
// master: drives the packed BCD value and its strobe, observes the scan outputs.
// slave:  the scanner itself.
interface seg7_scan_mux_if;
    logic [15:0] bcd_in;
    logic        bcd_valid;
    logic [3:0]  q_out;
    logic [3:0]  anode;
    logic [1:0]  digit_sel;
    logic        frame_tick;

    modport master (
        output bcd_in,
        output bcd_valid,
        input  q_out,
        input  anode,
        input  digit_sel,
        input  frame_tick
    );

    modport slave (
        input  bcd_in,
        input  bcd_valid,
        output q_out,
        output anode,
        output digit_sel,
        output frame_tick
    );
endinterface

// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed 4-digit scanner feeding one BCD->7-segment decoder.
// A prescaler splits time into digit slots; each slot starts with a short all-anodes-off
// guard to avoid ghosting. Incoming values land in a shadow register and are promoted to
// the display register only at a frame boundary, so a frame never shows a torn value.
// Optional feature: define SEG7_LZ_BLANK_EN for leading-zero suppression on digits 3..1.
module seg7_scan_mux #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic           clk,
    input  logic           rst_n,
    seg7_scan_mux_if.slave bus
);

    localparam int              CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [31:0]     BLANK_U = 32'(BLANK_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    digit_sel_q, digit_sel_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic [3:0]    q_out_q, q_out_d;
    logic [3:0]    anode_q, anode_d;
    logic          frame_tick_q, frame_tick_d;

    logic          cnt_wrap;
    logic          frame_end;
    logic          guard_done;
    logic [3:0]    blank_d;

    // Prescaler and digit stepping; the 3->0 wrap of the digit index is the frame boundary.
    always_comb begin
        cnt_wrap    = (cnt_q == CNT_MAX);
        frame_end   = cnt_wrap && (digit_sel_q == 2'd3);
        cnt_d       = cnt_wrap ? '0 : cnt_q + CW'(1);
        digit_sel_d = cnt_wrap ? digit_sel_q + 2'd1 : digit_sel_q;
    end

    // Double buffering: a strobe on the boundary cycle bypasses the shadow register.
    always_comb begin
        disp_d    = disp_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (frame_end) begin
            if (bus.bcd_valid) begin
                disp_d    = bus.bcd_in;
                shadow_d  = bus.bcd_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                disp_d    = shadow_q;
                pending_d = 1'b0;
            end
        end else if (bus.bcd_valid) begin
            shadow_d  = bus.bcd_in;
            pending_d = 1'b1;
        end
    end

    // Per-digit blanking mask derived from the value about to be displayed.
    always_comb begin
`ifdef SEG7_LZ_BLANK_EN
        blank_d[3] = (disp_d[15:12] == 4'd0);
        blank_d[2] = (disp_d[15:8]  == 8'd0);
        blank_d[1] = (disp_d[15:4]  == 12'd0);
        blank_d[0] = 1'b0;
`else
        blank_d    = 4'b0000;
`endif
    end

    // Output values from next-state signals so nibble, anode and index stay aligned.
    always_comb begin
        case (digit_sel_d)
            2'd0:    q_out_d = disp_d[3:0];
            2'd1:    q_out_d = disp_d[7:4];
            2'd2:    q_out_d = disp_d[11:8];
            default: q_out_d = disp_d[15:12];
        endcase
        guard_done = (32'(cnt_d) >= BLANK_U);
        anode_d    = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            if ((digit_sel_d == 2'(i)) && guard_done && !blank_d[i]) begin
                anode_d[i] = 1'b0;
            end
        end
        frame_tick_d = (cnt_d == '0) && (digit_sel_d == 2'd0);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            digit_sel_q  <= 2'd0;
            disp_q       <= 16'h0000;
            shadow_q     <= 16'h0000;
            pending_q    <= 1'b0;
            q_out_q      <= 4'd0;
            anode_q      <= 4'b1111;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            digit_sel_q  <= digit_sel_d;
            disp_q       <= disp_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            q_out_q      <= q_out_d;
            anode_q      <= anode_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign bus.q_out      = q_out_q;
    assign bus.anode      = anode_q;
    assign bus.digit_sel  = digit_sel_q;
    assign bus.frame_tick = frame_tick_q;

endmodule
